branch_unit: RTL and testbench
==============================

# branch_unit

Sequential consumer of the ALU status outputs in the Simple RISC Machine datapath. Latches Z/V/N into a status register on controller command, owns the program counter, and resolves conditional branches (B, BEQ, BNE, BLT, BLE) via a request/done handshake with the controller FSM. Sits between the ALU flag outputs and the instruction-memory address path.

## Interface

- PC_W, 9, program counter width (address space 2^PC_W words)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- load_s  input  1  capture Z_in/V_in/N_in into status register this edge
- Z_in, V_in, N_in  input  1 each  ALU status flags
- pc_inc  input  1  increment PC by 1 this edge (fetch)
- br_req  input  1  branch request, sampled only in IDLE
- cond  input  3  branch condition field
- imm8  input  8  signed branch offset, two's complement
- pc  output  PC_W  current program counter
- Z, V, N  output  1 each  registered status flags
- busy  output  1  high in EVAL and DONE
- br_done  output  1  one-cycle pulse, branch resolved and PC updated
- br_taken  output  1  valid while br_done high; 1 = PC loaded with target

## Operation

- Status register: on edge with load_s=1, {Z,V,N} <= {Z_in,V_in,N_in}; otherwise holds. load_s honoured in every state.
- Conditions (against registered flags, not inputs): 000 always; 001 Z=1; 010 Z=0; 011 N≠V; 100 (N≠V) or Z=1; 101–111 never taken.
- Target = (pc + sign_extend(imm8)) mod 2^PC_W; wrap in both directions. PC is already the address after the branch instruction (incremented at fetch); no extra +1.
- FSM states: IDLE, EVAL, DONE.
  - IDLE: br_req=1 -> latch cond, imm8; go EVAL. Else pc_inc=1 -> pc <= pc+1 mod 2^PC_W.
  - EVAL: evaluate condition on current registered flags; pc <= taken ? target : pc; register br_taken; go DONE.
  - DONE: br_done=1; go IDLE.
- pc_inc ignored in EVAL and DONE. br_req ignored in EVAL and DONE (no queuing).
- Same-edge br_req and pc_inc in IDLE: branch accepted, pc_inc dropped.
- Same-edge load_s and br_req: request captured; evaluation in EVAL sees the newly loaded flags (loaded on that same edge).
- load_s during EVAL edge: evaluation uses flags before that edge; new flags visible afterwards.

## Timing

- Reset (async, any state): state=IDLE, pc=0, Z=V=N=0, busy=0, br_done=0, br_taken=0; captured cond/imm cleared.
- Reset mid-branch: branch abandoned, no br_done pulse, PC=0.
- br_req sampled at edge T -> busy high after T; PC updated at edge T+1; br_done and br_taken high for the cycle after T+1; busy low and new br_req acceptable at edge T+2.
- pc_inc latency: pc updated on the same edge it is sampled.
- br_taken holds its value after br_done falls until the next EVAL; only meaningful with br_done.
- All outputs registered; no combinational path from inputs to outputs.

## Structure

- Shared package: condition encodings (COND_B, COND_BEQ, COND_BNE, COND_BLT, COND_BLE), FSM state encoding for IDLE/EVAL/DONE.
- Sub-module: branch_cond, combinational; inputs cond, Z, V, N; output taken. Reused later by the controller for decode checks.
- Top holds status register, PC register, FSM, target adder.

## Test plan

- Reset then pc_inc for 3 cycles -> pc = 3; assert reset mid-EVAL -> pc = 0, no br_done, Z=V=N=0.
- load_s with Z_in=1, then br_req cond=001 imm8=8'h05 at pc=3 -> br_done 2 cycles later, br_taken=1, pc=8; same with cond=010 -> br_taken=0, pc=3.
- Flags N=1,V=0: cond=011 imm8=8'hFE at pc=10 -> pc=8; N=0,V=0,Z=1: cond=100 -> taken; Z=0 -> not taken; cond=111 -> never taken.
- Wrap: pc=1, cond=000, imm8=8'hFC -> pc=509 (PC_W=9); pc=510, imm8=8'h04 -> pc=2.
- Simultaneous: br_req with pc_inc at pc=4, cond=010, Z=0, imm8=0 -> pc stays 4 (increment dropped); pc_inc and br_req held high during EVAL/DONE -> no extra increment, no second branch.
- load_s with Z_in=1 on same edge as br_req cond=001 -> taken; load_s Z_in=0 on EVAL edge with Z=1 previously -> still taken, Z=0 afterwards.

Source files
------------

// File: rtl/branch_unit_pkg.sv
// Shared encodings for the branch unit:
// branch condition codes and FSM states.
package branch_unit_pkg;

   localparam logic [2:0] COND_B   = 3'b000;
   localparam logic [2:0] COND_BEQ = 3'b001;
   localparam logic [2:0] COND_BNE = 3'b010;
   localparam logic [2:0] COND_BLT = 3'b011;
   localparam logic [2:0] COND_BLE = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EVAL = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/branch_unit_if.sv
// Controller <-> branch unit bundle:
// flag load, fetch increment and branch handshake.
interface branch_unit_if #(
   parameter int PC_W = 9
);
   logic            load_s;
   logic            Z_in;
   logic            V_in;
   logic            N_in;
   logic            pc_inc;
   logic            br_req;
   logic [2:0]      cond;
   logic [7:0]      imm8;
   logic [PC_W-1:0] pc;
   logic            Z;
   logic            V;
   logic            N;
   logic            busy;
   logic            br_done;
   logic            br_taken;

   modport master (
      output load_s, Z_in, V_in, N_in,
      output pc_inc, br_req, cond, imm8,
      input  pc, Z, V, N,
      input  busy, br_done, br_taken
   );

   modport slave (
      input  load_s, Z_in, V_in, N_in,
      input  pc_inc, br_req, cond, imm8,
      output pc, Z, V, N,
      output busy, br_done, br_taken
   );
endinterface

// File: rtl/branch_unit_cond.sv
// Branch condition decode against status flags.
// Codes 101..111 are never taken.
module branch_cond
   import branch_unit_pkg::*;
(
   input  logic [2:0] cond,
   input  logic       Z,
   input  logic       V,
   input  logic       N,
   output logic       taken
);

   // decode condition field into a take decision
   always_comb begin
      taken = 1'b0;
      unique case (cond)
         COND_B:   taken = 1'b1;
         COND_BEQ: taken = Z;
         COND_BNE: taken = ~Z;
         COND_BLT: taken = N ^ V;
         COND_BLE: taken = (N ^ V) | Z;
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_unit.sv
// Status register, program counter and
// branch-resolution FSM (IDLE -> EVAL -> DONE).
module branch_unit
   import branch_unit_pkg::*;
#(
   parameter int PC_W = 9
) (
   input logic          clk,
   input logic          reset,
   branch_unit_if.slave bus
);

   state_t          state;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] offs;
   logic            z_q;
   logic            v_q;
   logic            n_q;
   logic [2:0]      cond_q;
   logic [7:0]      imm_q;
   logic            busy_q;
   logic            done_q;
   logic            taken_q;
   logic            taken;

   branch_cond u_cond (
      .cond  (cond_q),
      .Z     (z_q),
      .V     (v_q),
      .N     (n_q),
      .taken (taken)
   );

   // PC already points past the branch, so the
   // target is a plain signed add with wrap.
   // Requires PC_W > 8.
   assign offs   = {{(PC_W-8){imm_q[7]}}, imm_q};
   assign target = pc_q + offs;

   // status flags load in any FSM state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         z_q <= 1'b0;
         v_q <= 1'b0;
         n_q <= 1'b0;
      end else if (bus.load_s) begin
         z_q <= bus.Z_in;
         v_q <= bus.V_in;
         n_q <= bus.N_in;
      end
   end

   // branch FSM with registered handshake outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         pc_q    <= '0;
         cond_q  <= '0;
         imm_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         taken_q <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.br_req) begin
                  cond_q <= bus.cond;
                  imm_q  <= bus.imm8;
                  busy_q <= 1'b1;
                  state  <= S_EVAL;
               end else if (bus.pc_inc) begin
                  pc_q <= pc_q + PC_W'(1);
               end
            end
            S_EVAL: begin
               if (taken) begin
                  pc_q <= target;
               end
               taken_q <= taken;
               done_q  <= 1'b1;
               state   <= S_DONE;
            end
            S_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.pc       = pc_q;
   assign bus.Z        = z_q;
   assign bus.V        = v_q;
   assign bus.N        = n_q;
   assign bus.busy     = busy_q;
   assign bus.br_done  = done_q;
   assign bus.br_taken = taken_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit against a
// behavioural PC/flag model.
module tb_branch_unit;

   localparam int PC_W = 9;
   localparam int PC_M = 1 << PC_W;

   logic clk;
   logic reset;

   branch_unit_if #(.PC_W(PC_W)) bus ();

   branch_unit #(.PC_W(PC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk;
   int n_fail;
   int m_pc;
   bit m_z;
   bit m_v;
   bit m_n;
   bit m_tk;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit rule(input bit [2:0] c,
                               input bit z, input bit v,
                               input bit n);
      bit lt;
      lt = (n != v);
      if (c == 3'd0) return 1'b1;
      if (c == 3'd1) return z;
      if (c == 3'd2) return !z;
      if (c == 3'd3) return lt;
      if (c == 3'd4) return lt || z;
      return 1'b0;
   endfunction

   function automatic int wrap(input int a);
      return ((a % PC_M) + PC_M) % PC_M;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.load_s = 1'b0;
      bus.Z_in   = 1'b0;
      bus.V_in   = 1'b0;
      bus.N_in   = 1'b0;
      bus.pc_inc = 1'b0;
      bus.br_req = 1'b0;
      bus.cond   = 3'd0;
      bus.imm8   = 8'd0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      tick();
      reset = 1'b0;
      m_pc = 0;
      m_z = 0;
      m_v = 0;
      m_n = 0;
      m_tk = 0;
   endtask

   task automatic set_pc(input int p);
      do_reset();
      bus.pc_inc = 1'b1;
      for (int i = 0; i < p; i++) tick();
      bus.pc_inc = 1'b0;
      m_pc = p;
      n_chk++;
      if (bus.pc !== PC_W'(m_pc)) begin
         n_fail++;
         $display("FAIL set_pc: got %0d want %0d",
                  bus.pc, m_pc);
      end
   endtask

   task automatic load_flags(input bit [2:0] f);
      bus.load_s = 1'b1;
      {bus.Z_in, bus.V_in, bus.N_in} = f;
      tick();
      bus.load_s = 1'b0;
      {m_z, m_v, m_n} = f;
      n_chk++;
      if ({bus.Z, bus.V, bus.N} !== f) begin
         n_fail++;
         $display("FAIL load_flags: got %b want %b",
                  {bus.Z, bus.V, bus.N}, f);
      end
   endtask

   // one full branch transaction with optional
   // same-edge inc/load and held request lines
   task automatic run_branch(input string nm,
                             input bit [2:0] c,
                             input bit [7:0] im,
                             input bit inc, input bit hold,
                             input bit ld0, input bit [2:0] f0,
                             input bit ld1, input bit [2:0] f1);
      bit tk;
      int ep;
      bus.br_req = 1'b1;
      bus.cond   = c;
      bus.imm8   = im;
      bus.pc_inc = inc;
      bus.load_s = ld0;
      {bus.Z_in, bus.V_in, bus.N_in} = f0;
      tick();
      if (ld0) {m_z, m_v, m_n} = f0;
      n_chk++;
      if ({bus.busy, bus.br_done} !== 2'b10 ||
          bus.pc !== PC_W'(m_pc)) begin
         n_fail++;
         $display("FAIL %s accept: busy/done=%b%b pc=%0d want 10 pc=%0d",
                  nm, bus.busy, bus.br_done, bus.pc, m_pc);
      end
      bus.br_req = hold;
      bus.pc_inc = hold & inc;
      bus.cond   = ~c;
      bus.imm8   = ~im;
      bus.load_s = ld1;
      {bus.Z_in, bus.V_in, bus.N_in} = f1;
      tick();
      tk = rule(c, m_z, m_v, m_n);
      ep = tk ? wrap(m_pc + int'($signed(im))) : m_pc;
      m_pc = ep;
      m_tk = tk;
      if (ld1) {m_z, m_v, m_n} = f1;
      n_chk++;
      if (bus.pc !== PC_W'(m_pc)) begin
         n_fail++;
         $display("FAIL %s pc: got %0d want %0d",
                  nm, bus.pc, m_pc);
      end
      n_chk++;
      if ({bus.busy, bus.br_done, bus.br_taken} !==
          {2'b11, m_tk}) begin
         n_fail++;
         $display("FAIL %s done: busy/done/taken=%b%b%b want 11%b",
                  nm, bus.busy, bus.br_done, bus.br_taken, m_tk);
      end
      n_chk++;
      if ({bus.Z, bus.V, bus.N} !== {m_z, m_v, m_n}) begin
         n_fail++;
         $display("FAIL %s flags: got %b want %b", nm,
                  {bus.Z, bus.V, bus.N}, {m_z, m_v, m_n});
      end
      bus.load_s = 1'b0;
      tick();
      bus.br_req = 1'b0;
      bus.pc_inc = 1'b0;
      n_chk++;
      if ({bus.busy, bus.br_done, bus.br_taken} !==
          {2'b00, m_tk} || bus.pc !== PC_W'(m_pc)) begin
         n_fail++;
         $display("FAIL %s end: busy/done/taken=%b%b%b pc=%0d want 00%b pc=%0d",
                  nm, bus.busy, bus.br_done, bus.br_taken,
                  bus.pc, m_tk, m_pc);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if (bus.pc !== '0 || {bus.Z, bus.V, bus.N} !== 3'b000 ||
          {bus.busy, bus.br_done, bus.br_taken} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset: pc=%0d zvn=%b bdt=%b%b%b want 0",
                  bus.pc, {bus.Z, bus.V, bus.N},
                  bus.busy, bus.br_done, bus.br_taken);
      end
   endtask

   task automatic test_pc_inc();
      bus.pc_inc = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_chk++;
         if (bus.pc !== PC_W'(i)) begin
            n_fail++;
            $display("FAIL pc_inc: got %0d want %0d", bus.pc, i);
         end
      end
      bus.pc_inc = 1'b0;
      m_pc = 3;
   endtask

   task automatic test_reset_mid();
      load_flags(3'b111);
      bus.br_req = 1'b1;
      bus.cond   = 3'd0;
      bus.imm8   = 8'h05;
      tick();
      bus.br_req = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      n_chk++;
      if (bus.pc !== '0 || {bus.Z, bus.V, bus.N} !== 3'b000 ||
          {bus.busy, bus.br_done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_mid: pc=%0d zvn=%b busy/done=%b%b want 0",
                  bus.pc, {bus.Z, bus.V, bus.N},
                  bus.busy, bus.br_done);
      end
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++;
         if (bus.br_done !== 1'b0 || bus.pc !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_after: done=%b pc=%0d want 0 0",
                     bus.br_done, bus.pc);
         end
      end
      m_pc = 0;
      {m_z, m_v, m_n} = 3'b000;
      m_tk = 0;
   endtask

   task automatic test_conditions();
      set_pc(3);
      load_flags(3'b100);
      run_branch("beq_taken", 3'b001, 8'h05, 0, 0, 0, 0, 0, 0);
      n_chk++;
      if (bus.pc !== 9'd8) begin
         n_fail++;
         $display("FAIL beq_pc8: got %0d want 8", bus.pc);
      end
      set_pc(3);
      load_flags(3'b100);
      run_branch("bne_not", 3'b010, 8'h05, 0, 0, 0, 0, 0, 0);
      set_pc(10);
      load_flags(3'b001);
      run_branch("blt_back", 3'b011, 8'hFE, 0, 0, 0, 0, 0, 0);
      n_chk++;
      if (bus.pc !== 9'd8) begin
         n_fail++;
         $display("FAIL blt_pc8: got %0d want 8", bus.pc);
      end
      load_flags(3'b100);
      run_branch("ble_z", 3'b100, 8'h10, 0, 0, 0, 0, 0, 0);
      load_flags(3'b000);
      run_branch("ble_not", 3'b100, 8'h10, 0, 0, 0, 0, 0, 0);
      load_flags(3'b111);
      run_branch("never7", 3'b111, 8'h10, 0, 0, 0, 0, 0, 0);
      run_branch("never5", 3'b101, 8'h10, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_wrap();
      set_pc(1);
      run_branch("wrap_down", 3'b000, 8'hFC, 0, 0, 0, 0, 0, 0);
      n_chk++;
      if (bus.pc !== 9'd509) begin
         n_fail++;
         $display("FAIL wrap_down_pc: got %0d want 509", bus.pc);
      end
      set_pc(510);
      run_branch("wrap_up", 3'b000, 8'h04, 0, 0, 0, 0, 0, 0);
      n_chk++;
      if (bus.pc !== 9'd2) begin
         n_fail++;
         $display("FAIL wrap_up_pc: got %0d want 2", bus.pc);
      end
   endtask

   task automatic test_simultaneous();
      set_pc(4);
      run_branch("req_inc", 3'b010, 8'h00, 1, 0, 0, 0, 0, 0);
      run_branch("held", 3'b010, 8'h03, 1, 1, 0, 0, 0, 0);
   endtask

   task automatic test_load_same_edge();
      load_flags(3'b000);
      run_branch("load_req", 3'b001, 8'h02, 0, 0, 1, 3'b100,
                 0, 0);
      run_branch("load_eval", 3'b001, 8'h02, 0, 0, 0, 0,
                 1, 3'b000);
      n_chk++;
      if (bus.Z !== 1'b0 || bus.br_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL load_eval_z: Z=%b taken=%b want 0 1",
                  bus.Z, bus.br_taken);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++) begin
         int op;
         op = $urandom_range(0, 3);
         if (op == 0) begin
            int k;
            k = $urandom_range(1, 4);
            bus.pc_inc = 1'b1;
            for (int j = 0; j < k; j++) begin
               tick();
               m_pc = wrap(m_pc + 1);
               n_chk++;
               if (bus.pc !== PC_W'(m_pc)) begin
                  n_fail++;
                  $display("FAIL rand_inc: got %0d want %0d",
                           bus.pc, m_pc);
               end
            end
            bus.pc_inc = 1'b0;
         end else if (op == 1) begin
            load_flags(3'($urandom_range(0, 7)));
         end else begin
            run_branch("rand_br",
                       3'($urandom_range(0, 7)),
                       8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)));
         end
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      idle_inputs();
      reset = 1'b1;
      tick();
      test_reset();
      test_pc_inc();
      test_reset_mid();
      test_conditions();
      test_wrap();
      test_simultaneous();
      test_load_same_edge();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
